pkt_frame_fsm: RTL and testbench



---
 rtl/pkt_frame_pkg.sv | 36 +++
 rtl/pkt_frame_chan.sv | 207 ++++++++++++++++++++
 rtl/pkt_frame_fsm.sv | 59 +++++
 tb/tb_pkt_frame_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_frame_pkg.sv
// -----------------------------------------------------------------------------
// pkt_frame_pkg
// Shared types and helpers for the packet-framing tracker:
//   state_e    : per-channel framing FSM state (IDLE / BODY / DRAIN)
//   err_code_e : framing error classification
//   sat_inc    : saturating increment used by the packet and error counters
// -----------------------------------------------------------------------------
package pkt_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BODY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ORPHAN  = 2'd1,
    ERR_NESTED  = 2'd2,
    ERR_OVERLEN = 2'd3
  } err_code_e;

  // Increment val by one unless it has already reached max_val. Callers pass
  // counters zero-extended to 32 bits and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pkt_frame_chan.sv
// -----------------------------------------------------------------------------
// pkt_frame_chan
// One framing channel: head/tail/valid FSM, beat-length counter, completion and
// error pulses, sticky error code and saturating packet/error counters.
// Ports:
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   clear            : synchronous clear of counters and sticky error code
//   valid/head/tail  : beat qualifiers for this channel
//   state            : current FSM state
//   pkt_done, err    : one-cycle event pulses
//   pkt_len          : length of the last completed packet (held)
//   err_code         : most recent error code (held until next error / clear)
//   pkt_count        : saturating count of completed packets
//   err_count        : saturating count of framing errors
// -----------------------------------------------------------------------------
module pkt_frame_chan
  import pkt_frame_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             valid,
  input  logic             head,
  input  logic             tail,
  output logic [1:0]       state,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [31:0]      CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_done_q, pkt_done_d;
  logic             err_q, err_d;
  err_code_e        err_code_q, err_code_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Events decided by the next-state logic, consumed by the output logic.
  logic             done_s;
  logic             err_s;
  err_code_e        code_s;
  logic [LEN_W-1:0] done_len_s;
  logic [LEN_W-1:0] len_inc_s;

  // State register: every flop of the channel, async reset to idle values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_ZERO;
      pkt_len_q   <= LEN_ZERO;
      pkt_done_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      pkt_count_q <= {CNT_W{1'b0}};
      err_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pkt_len_q   <= pkt_len_d;
      pkt_done_q  <= pkt_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic: walks the framing rules for the current beat.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    done_s     = 1'b0;
    err_s      = 1'b0;
    code_s     = ERR_NONE;
    done_len_s = len_q;
    len_inc_s  = len_q + LEN_ONE;
    if (valid) begin
      case (state_q)
        ST_BODY: begin
          if (head) begin
            // Nested head: flag it, then restart as a fresh packet.
            err_s  = 1'b1;
            code_s = ERR_NESTED;
            if (tail) begin
              done_s     = 1'b1;
              done_len_s = LEN_ONE;
              state_d    = ST_IDLE;
              len_d      = LEN_ZERO;
            end else begin
              state_d = ST_BODY;
              len_d   = LEN_ONE;
            end
          end else if (tail) begin
            // A tail on beat MAX_LEN is still a legal completion.
            done_s     = 1'b1;
            done_len_s = len_inc_s;
            state_d    = ST_IDLE;
            len_d      = LEN_ZERO;
          end else if (len_inc_s == MAX_LEN_L) begin
            err_s   = 1'b1;
            code_s  = ERR_OVERLEN;
            state_d = ST_DRAIN;
            len_d   = LEN_ZERO;
          end else begin
            len_d = len_inc_s;
          end
        end
        ST_DRAIN: begin
          if (head) begin
            if (tail) begin
              done_s     = 1'b1;
              done_len_s = LEN_ONE;
              state_d    = ST_IDLE;
              len_d      = LEN_ZERO;
            end else begin
              state_d = ST_BODY;
              len_d   = LEN_ONE;
            end
          end else if (tail) begin
            // Tail of the over-length packet closes it silently.
            state_d = ST_IDLE;
            len_d   = LEN_ZERO;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          // IDLE, and the unreachable encoding 3 which behaves as IDLE.
          if (head) begin
            if (tail) begin
              done_s     = 1'b1;
              done_len_s = LEN_ONE;
              state_d    = ST_IDLE;
              len_d      = LEN_ZERO;
            end else begin
              state_d = ST_BODY;
              len_d   = LEN_ONE;
            end
          end else begin
            err_s   = 1'b1;
            code_s  = ERR_ORPHAN;
            state_d = ST_IDLE;
            len_d   = LEN_ZERO;
          end
        end
      endcase
    end else begin
      state_d = state_q;
      len_d   = len_q;
    end
  end

  // Output logic: pulses, held length/code and saturating counters.
  always_comb begin
    pkt_done_d = done_s;
    err_d      = err_s;
    if (done_s) begin
      pkt_len_d = done_len_s;
    end else begin
      pkt_len_d = pkt_len_q;
    end
    if (clear) begin
      err_code_d  = ERR_NONE;
      pkt_count_d = {CNT_W{1'b0}};
      err_count_d = {CNT_W{1'b0}};
    end else begin
      if (err_s) begin
        err_code_d = code_s;
      end else begin
        err_code_d = err_code_q;
      end
      if (done_s) begin
        pkt_count_d = CNT_W'(sat_inc(32'(pkt_count_q), CNT_MAX));
      end else begin
        pkt_count_d = pkt_count_q;
      end
      if (err_s) begin
        err_count_d = CNT_W'(sat_inc(32'(err_count_q), CNT_MAX));
      end else begin
        err_count_d = err_count_q;
      end
    end
  end

  assign state     = state_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_len   = pkt_len_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

endmodule

// File: rtl/pkt_frame_fsm.sv
// -----------------------------------------------------------------------------
// pkt_frame_fsm
// Multi-channel passive packet-framing tracker. Packs CHANNELS independent
// pkt_frame_chan instances onto flat vector ports.
// Ports:
//   clock, reset, clear : shared clock, async active-high reset, sync clear
//   valid, head, tail   : per-channel beat qualifiers (bit i = channel i)
//   state               : 2 bits per channel
//   pkt_done, err       : per-channel one-cycle pulses
//   pkt_len             : LEN_W bits per channel
//   err_code            : 2 bits per channel
//   pkt_count/err_count : CNT_W bits per channel
// -----------------------------------------------------------------------------
module pkt_frame_fsm
  import pkt_frame_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MAX_LEN  = 16,
  parameter int CNT_W    = 8,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS-1:0]       head,
  input  logic [CHANNELS-1:0]       tail,
  output logic [2*CHANNELS-1:0]     state,
  output logic [CHANNELS-1:0]       pkt_done,
  output logic [LEN_W*CHANNELS-1:0] pkt_len,
  output logic [CHANNELS-1:0]       err,
  output logic [2*CHANNELS-1:0]     err_code,
  output logic [CNT_W*CHANNELS-1:0] pkt_count,
  output logic [CNT_W*CHANNELS-1:0] err_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pkt_frame_chan #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .LEN_W   (LEN_W)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .valid     (valid[i]),
      .head      (head[i]),
      .tail      (tail[i]),
      .state     (state[2*i +: 2]),
      .pkt_done  (pkt_done[i]),
      .pkt_len   (pkt_len[LEN_W*i +: LEN_W]),
      .err       (err[i]),
      .err_code  (err_code[2*i +: 2]),
      .pkt_count (pkt_count[CNT_W*i +: CNT_W]),
      .err_count (err_count[CNT_W*i +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pkt_frame_fsm.sv
// -----------------------------------------------------------------------------
// tb_pkt_frame_fsm
// Self-checking bench: directed framing scenarios followed by randomized beat
// traffic, every cycle compared against a per-channel packet-level model.
// -----------------------------------------------------------------------------
module tb_pkt_frame_fsm;

  localparam int CH    = 4;
  localparam int ML    = 16;
  localparam int CW    = 2;
  localparam int LW    = $clog2(ML + 1);
  localparam int CMAX  = (1 << CW) - 1;

  logic                clock;
  logic                reset;
  logic                clear;
  logic [CH-1:0]       valid;
  logic [CH-1:0]       head;
  logic [CH-1:0]       tail;
  logic [2*CH-1:0]     state;
  logic [CH-1:0]       pkt_done;
  logic [LW*CH-1:0]    pkt_len;
  logic [CH-1:0]       err;
  logic [2*CH-1:0]     err_code;
  logic [CW*CH-1:0]    pkt_count;
  logic [CW*CH-1:0]    err_count;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: packet-level view of each channel.
  bit in_pkt   [CH];
  bit draining [CH];
  int beats    [CH];
  int last_len [CH];
  int last_code[CH];
  int pc       [CH];
  int ec       [CH];
  bit exp_done [CH];
  bit exp_err  [CH];

  pkt_frame_fsm #(
    .CHANNELS (CH),
    .MAX_LEN  (ML),
    .CNT_W    (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .valid     (valid),
    .head      (head),
    .tail      (tail),
    .state     (state),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .err       (err),
    .err_code  (err_code),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int ch,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)", tag, ch, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      in_pkt[c] = 1'b0; draining[c] = 1'b0; beats[c] = 0;
      last_len[c] = 0; last_code[c] = 0; pc[c] = 0; ec[c] = 0;
      exp_done[c] = 1'b0; exp_err[c] = 1'b0;
    end
  endtask

  task automatic model_tick(input logic [CH-1:0] v, input logic [CH-1:0] h,
                            input logic [CH-1:0] t, input logic clr);
    for (int c = 0; c < CH; c++) begin
      exp_done[c] = 1'b0;
      exp_err[c]  = 1'b0;
      if (v[c]) begin
        if (h[c]) begin
          if (in_pkt[c]) begin exp_err[c] = 1'b1; last_code[c] = 2; end
          draining[c] = 1'b0;
          if (t[c]) begin
            exp_done[c] = 1'b1; last_len[c] = 1; in_pkt[c] = 1'b0;
          end else begin
            in_pkt[c] = 1'b1; beats[c] = 1;
          end
        end else if (in_pkt[c]) begin
          beats[c]++;
          if (t[c]) begin
            exp_done[c] = 1'b1; last_len[c] = beats[c]; in_pkt[c] = 1'b0;
          end else if (beats[c] == ML) begin
            exp_err[c] = 1'b1; last_code[c] = 3; in_pkt[c] = 1'b0; draining[c] = 1'b1;
          end
        end else if (draining[c]) begin
          if (t[c]) draining[c] = 1'b0;
        end else begin
          exp_err[c] = 1'b1; last_code[c] = 1;
        end
      end
      if (clr) begin
        pc[c] = 0; ec[c] = 0; last_code[c] = 0;
      end else begin
        if (exp_done[c] && pc[c] < CMAX) pc[c]++;
        if (exp_err[c] && ec[c] < CMAX) ec[c]++;
      end
    end
  endtask

  task automatic check_all();
    int exp_state;
    for (int c = 0; c < CH; c++) begin
      exp_state = in_pkt[c] ? 1 : (draining[c] ? 2 : 0);
      check("state",     c, 32'(state[2*c +: 2]),       32'(exp_state));
      check("pkt_done",  c, 32'(pkt_done[c]),           32'(exp_done[c]));
      check("pkt_len",   c, 32'(pkt_len[LW*c +: LW]),   32'(last_len[c]));
      check("err",       c, 32'(err[c]),                32'(exp_err[c]));
      check("err_code",  c, 32'(err_code[2*c +: 2]),    32'(last_code[c]));
      check("pkt_count", c, 32'(pkt_count[CW*c +: CW]), 32'(pc[c]));
      check("err_count", c, 32'(err_count[CW*c +: CW]), 32'(ec[c]));
    end
  endtask

  // Apply one beat pattern for one clock, then compare one time unit later.
  task automatic step(input logic [CH-1:0] v, input logic [CH-1:0] h,
                      input logic [CH-1:0] t, input logic clr);
    valid = v; head = h; tail = t; clear = clr;
    @(posedge clock);
    #1;
    model_tick(v, h, t, clr);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [CH-1:0] rv, rh, rt;
    logic          rc;
    int            hp, tp;

    reset = 1'b1; clear = 1'b0;
    valid = 4'b0000; head = 4'b0000; tail = 4'b0000;
    model_reset();
    #19;
    check_all();
    #1 reset = 1'b0;

    // ch0: head then tail -> length 2.
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 4'b0001, 1'b0);
    idle(2);

    // ch1: three back-to-back single-beat packets.
    for (int i = 0; i < 3; i++) step(4'b0010, 4'b0010, 4'b0010, 1'b0);
    idle(1);

    // ch2: orphan tail, then head, nested head, tail.
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    step(4'b0100, 4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0000, 4'b0100, 1'b0);
    idle(1);

    // ch3: over-length packet, drained by 3 beats and a tail.
    step(4'b1000, 4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < ML - 1; i++) step(4'b1000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 4'b1000, 1'b0);
    idle(1);

    // ch3: tail exactly on beat MAX_LEN is legal.
    step(4'b1000, 4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < ML - 2; i++) step(4'b1000, 4'b0000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 4'b1000, 1'b0);
    idle(1);

    // ch0: counter saturation, then clear colliding with a completion.
    for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0001, 4'b0001, 1'b1);
    idle(1);

    // Asynchronous reset in the middle of a packet, between clock edges.
    step(4'b0001, 4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    valid = 4'b0001; head = 4'b0000; tail = 4'b0000;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    idle(2);

    // Randomized traffic: a head-heavy phase, then a long-packet phase.
    for (int phase = 0; phase < 2; phase++) begin
      hp = (phase == 0) ? 30 : 4;
      tp = (phase == 0) ? 30 : 5;
      for (int n = 0; n < 300; n++) begin
        for (int c = 0; c < CH; c++) begin
          rv[c] = ($urandom_range(0, 99) < 75);
          rh[c] = ($urandom_range(0, 99) < hp);
          rt[c] = ($urandom_range(0, 99) < tp);
        end
        rc = ($urandom_range(0, 99) < 3);
        step(rv, rh, rt, rc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
